do_xung: RTL and testbench
==========================

// Module: do_xung
// PURPOSE
//  Pulse-train receiver/meter: measures high time and period of an external square
//  wave on PulseIn and classifies it against the four mode timings of the pulse
//  generator (mode 0..3). Sits on the input side of the test board. Its results feed
//  the status/display logic and loop back to check the generator's output.
// PARAMETERS
//  CNT_W      25          width of high/period counters and outputs
//  NOM0       1000        nominal period, mode 0 (clk cycles)
//  NOM1       5000        nominal period, mode 1
//  NOM2       2000        nominal period, mode 2
//  NOM3       10000000    nominal period, mode 3
//  TOL_SHIFT  5           period match window = +/- (NOMx >> TOL_SHIFT)
//  TIMEOUT    20000000    cycles without a rising edge before timeout (< 2**CNT_W)
//  FILT_LEN   4           glitch-filter stability length, cycles (GLITCH_FILTER_EN only)
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      asynchronous active-low reset
//  PulseIn     in   1      asynchronous pulse input
//  high_cnt    out  CNT_W  high time of last complete period, clk cycles
//  period_cnt  out  CNT_W  last complete period (rise to rise), clk cycles
//  meas_valid  out  1      1-cycle strobe: high_cnt/period_cnt/mode/mode_ok updated
//  mode        out  2      detected mode (valid when mode_ok=1)
//  mode_ok     out  1      last period matched a mode window, duty within window
//  timeout     out  1      level: no rising edge for TIMEOUT cycles
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, counters 0, sync regs 0, FSM=IDLE.
//  Input: 2-FF synchronizer, then edge detect on sync output (rise/fall = 1-cycle pulses).
//  Latency: outputs register on the 2nd clk edge after the edge first sampling PulseIn=1.
//  FSM states:
//   IDLE  : counters held 0; rise -> HIGH (clear cnt_p=1, cnt_h=1). No output update.
//   HIGH  : cnt_p++, cnt_h++; fall -> LOW (cnt_h frozen).
//   LOW   : cnt_p++; rise -> publish, then HIGH with cnt_p=1, cnt_h=1.
//   Any state except IDLE: cnt_p reaching TIMEOUT -> timeout=1, mode_ok=0, -> IDLE.
//  Publish (rise in LOW): period_cnt<=cnt_p, high_cnt<=cnt_h, meas_valid=1 one cycle,
//   timeout<=0. First rise after reset/timeout only starts measurement, never publishes.
//  Classification (same cycle as publish): mode = lowest x with
//   |cnt_p - NOMx| <= NOMx>>TOL_SHIFT; mode_ok=1 only if a match exists AND
//   |2*cnt_h - cnt_p| <= cnt_p>>TOL_SHIFT; otherwise mode_ok=0, mode holds old value.
//  Arithmetic: compares in CNT_W+1 bits, no overflow; counters saturate at TIMEOUT.
//  Rise and fall in same cycle impossible after sync; in HIGH a rise is ignored, in LOW
//   a fall is ignored.
//  Constant-high input: stays in HIGH until TIMEOUT -> timeout=1; needs new rise.
//  timeout clears only on the next publish. It does not clear on the restarting rise.
//  high_cnt/period_cnt/mode hold their values across timeout.
// CONFIGURATION
//  GLITCH_FILTER_EN defined: filter between synchronizer and edge detector. Filtered
//   level changes only after the sync output is stable for FILT_LEN consecutive cycles.
//   Pulses shorter than FILT_LEN are rejected. Latency grows by FILT_LEN cycles.
//   Filter resets to 0.
//  Not defined: edge detector driven directly by the synchronizer; no filter logic.
// TESTING
//  1 Generator mode 0 (500 high / 501 low) -> after 2nd rise meas_valid=1,
//    high_cnt=500, period_cnt=1001, mode=0, mode_ok=1.
//  2 Sweep modes 1,2,3 (2500/5000, 1000/2000, 5e6/1e7) -> mode=1,2,3, mode_ok=1
//    each, one meas_valid per period.
//  3 Period 1500, 50% duty -> mode_ok=0, mode unchanged. 1000 period at 25% duty
//    (250 high) -> mode_ok=0.
//  4 Hold PulseIn high after one rise -> timeout=1 exactly TIMEOUT cycles after
//    that rise. Next two rises -> one meas_valid, timeout=0.
//  5 Assert rst_n=0 mid-HIGH for 3 cycles -> all outputs 0 immediately. First
//    publish after that needs two new rises.
//  6 GLITCH_FILTER_EN: 2-cycle low glitch inside the high phase of mode 0 ->
//    high_cnt=500, mode_ok=1. Without the macro -> period broken, mode_ok=0.

Source files
------------

// File: rtl/do_xung.sv
// do_xung: pulse-train meter. Measures the high time and the period of PulseIn
// in clk cycles and classifies each complete period against four nominal mode
// periods, also checking that the duty cycle is close to 50%.
// Optional feature macro: GLITCH_FILTER_EN. When it is defined, a stability
// filter sits between the synchronizer and the edge detector. Pulses shorter
// than FILT_LEN cycles are rejected, and edge latency grows by FILT_LEN cycles.
//
// state | meaning
// IDLE  | no measurement running, counters held at 0, waiting for a rise
// HIGH  | input high, period and high counters both running
// LOW   | input low, period counter running, high counter frozen
module do_xung #(
    parameter int unsigned CNT_W     = 25,
    parameter int unsigned NOM0      = 1000,
    parameter int unsigned NOM1      = 5000,
    parameter int unsigned NOM2      = 2000,
    parameter int unsigned NOM3      = 10000000,
    parameter int unsigned TOL_SHIFT = 5,
    parameter int unsigned TIMEOUT   = 20000000,
    parameter int unsigned FILT_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PulseIn,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic [1:0]       mode,
    output logic             mode_ok,
    output logic             timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    localparam int unsigned NOMS [4] = '{NOM0, NOM1, NOM2, NOM3};
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

    // Reject parameter sets where the counters could not reach TIMEOUT
    if (TIMEOUT == 0 || 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
        $error("do_xung: TIMEOUT must lie in 1 .. 2**CNT_W-1");
    end
    if (FILT_LEN == 0) begin : g_bad_filt_len
        $error("do_xung: FILT_LEN must be at least 1");
    end

    logic             sync1_q, sync2_q;
    logic             lvl, lvl_q, rise, fall;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_p_q, cnt_h_q, high_q, period_q;
    logic [1:0]       mode_q;
    logic             mode_ok_q, valid_q, timeout_q;
    logic             tmo_hit;
    logic [CNT_W:0]   p_ext, h2_ext, nom_c, tol_c, diff_c, duty_diff;
    logic             match, duty_ok;
    logic [1:0]       match_mode;

    // Two-flop synchronizer for the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= PulseIn;
            sync2_q <= sync1_q;
        end
    end

`ifdef GLITCH_FILTER_EN
    localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    logic [FCW-1:0] filt_cnt_q;
    logic           filt_q;

    // Filtered level flips only after FILT_LEN consecutive samples disagree with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FCW'(FILT_LEN - 1)) begin
            filt_q     <= sync2_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FCW'(1);
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    // Previous conditioned level for single-cycle edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= 1'b0;
        else        lvl_q <= lvl;
    end

    assign rise    = lvl & ~lvl_q;
    assign fall    = ~lvl & lvl_q;
    assign tmo_hit = (cnt_p_q >= TMO_C);

    // Period window match (lowest mode wins) and duty window, one bit wider than the counters
    always_comb begin
        match      = 1'b0;
        match_mode = 2'd0;
        nom_c      = '0;
        tol_c      = '0;
        diff_c     = '0;
        p_ext      = {1'b0, cnt_p_q};
        h2_ext     = {cnt_h_q, 1'b0};
        for (int i = 3; i >= 0; i--) begin
            nom_c  = (CNT_W + 1)'(NOMS[i]);
            tol_c  = nom_c >> TOL_SHIFT;
            diff_c = (p_ext >= nom_c) ? (p_ext - nom_c) : (nom_c - p_ext);
            if (diff_c <= tol_c) begin
                match      = 1'b1;
                match_mode = 2'(i);
            end
        end
        duty_diff = (h2_ext >= p_ext) ? (h2_ext - p_ext) : (p_ext - h2_ext);
        duty_ok   = (duty_diff <= (p_ext >> TOL_SHIFT));
    end

    // Measurement FSM: runs the counters, publishes and classifies on each closing rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_p_q   <= '0;
            cnt_h_q   <= '0;
            high_q    <= '0;
            period_q  <= '0;
            mode_q    <= 2'd0;
            mode_ok_q <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q <= ST_HIGH;
                        cnt_p_q <= CNT_W'(1);
                        cnt_h_q <= CNT_W'(1);
                    end else begin
                        cnt_p_q <= '0;
                        cnt_h_q <= '0;
                    end
                end
                ST_HIGH: begin
                    if (tmo_hit) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                        mode_ok_q <= 1'b0;
                        cnt_p_q   <= '0;
                        cnt_h_q   <= '0;
                    end else begin
                        cnt_p_q <= cnt_p_q + CNT_W'(1);
                        if (fall) state_q <= ST_LOW;
                        else      cnt_h_q <= cnt_h_q + CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (tmo_hit) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                        mode_ok_q <= 1'b0;
                        cnt_p_q   <= '0;
                        cnt_h_q   <= '0;
                    end else if (rise) begin
                        // Publish the period that this rise closes, then start the next one
                        period_q  <= cnt_p_q;
                        high_q    <= cnt_h_q;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b0;
                        mode_ok_q <= match & duty_ok;
                        if (match && duty_ok) mode_q <= match_mode;
                        state_q   <= ST_HIGH;
                        cnt_p_q   <= CNT_W'(1);
                        cnt_h_q   <= CNT_W'(1);
                    end else begin
                        cnt_p_q <= cnt_p_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_p_q <= '0;
                    cnt_h_q <= '0;
                end
            endcase
        end
    end

    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign meas_valid = valid_q;
    assign mode       = mode_q;
    assign mode_ok    = mode_ok_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_do_xung.sv
// Bench for do_xung. A timestamp-based reference model (times of rises and
// falls of the input as seen after the synchronizer) predicts every output on
// every cycle; directed sequences pin the model with hand-computed values.
module tb_do_xung;

    localparam int unsigned CNT_W     = 25;
    localparam int unsigned NOM0      = 100;
    localparam int unsigned NOM1      = 500;
    localparam int unsigned NOM2      = 200;
    localparam int unsigned NOM3      = 2000;
    localparam int unsigned TOL_SHIFT = 5;
    localparam int unsigned TIMEOUT   = 5000;
    localparam int unsigned FILT_LEN  = 4;
`ifdef GLITCH_FILTER_EN
    localparam int LAT = 2 + FILT_LEN;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             PulseIn = 1'b0;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic             meas_valid, mode_ok, timeout;
    logic [1:0]       mode;

    do_xung #(
        .CNT_W(CNT_W), .NOM0(NOM0), .NOM1(NOM1), .NOM2(NOM2), .NOM3(NOM3),
        .TOL_SHIFT(TOL_SHIFT), .TIMEOUT(TIMEOUT), .FILT_LEN(FILT_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PulseIn(PulseIn),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .meas_valid(meas_valid),
        .mode(mode), .mode_ok(mode_ok), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_valid = 0;
    bit          chk_en = 1'b0;
    int          cur_mode = 0;

    // Reference model state
    longint noms [4] = '{NOM0, NOM1, NOM2, NOM3};
    bit     hist[$];
    bit     lvl_prev;
    bit     armed, in_low;
    longint t_now, t_rise, t_fall;
    longint m_high, m_period;
    bit     m_valid, m_ok, m_tmo;
    longint m_mode;
`ifdef GLITCH_FILTER_EN
    bit     win[$];
    bit     filt_lvl;
`endif

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
`ifdef GLITCH_FILTER_EN
        win.delete();
        filt_lvl = 1'b0;
`endif
        lvl_prev = 1'b0;
        armed = 1'b0; in_low = 1'b0;
        t_now = 0; t_rise = 0; t_fall = 0;
        m_high = 0; m_period = 0; m_mode = 0;
        m_valid = 1'b0; m_ok = 1'b0; m_tmo = 1'b0;
    endtask

    function automatic longint absdiff(input longint a, input longint b);
        return (a >= b) ? a - b : b - a;
    endfunction

    task automatic publish(input longint per, input longint hi);
        bit     found = 1'b0;
        longint fm = 0;
        for (int x = 0; x < 4; x++)
            if (!found && absdiff(per, noms[x]) <= (noms[x] >> TOL_SHIFT)) begin
                found = 1'b1;
                fm = x;
            end
        m_valid  = 1'b1;
        m_tmo    = 1'b0;
        m_period = per;
        m_high   = hi;
        if (found && absdiff(2 * hi, per) <= (per >> TOL_SHIFT)) begin
            m_ok   = 1'b1;
            m_mode = fm;
        end else begin
            m_ok = 1'b0;
        end
    endtask

    // One clock edge of the model: p is the input value sampled at this edge
    task automatic model_step(input bit p);
        bit v, lvl, rise, fall;
        t_now++;
        hist.push_back(p);
        v = hist.pop_front();
`ifdef GLITCH_FILTER_EN
        begin
            bit same = 1'b1;
            win.push_back(v);
            if (win.size() > FILT_LEN) void'(win.pop_front());
            foreach (win[i]) if (win[i] != v) same = 1'b0;
            lvl = filt_lvl;
            if (win.size() == FILT_LEN && same) filt_lvl = v;
        end
`else
        lvl = v;
`endif
        rise = lvl & ~lvl_prev;
        fall = ~lvl & lvl_prev;
        lvl_prev = lvl;
        m_valid = 1'b0;
        if (armed && (t_now - t_rise) >= TIMEOUT) begin
            m_tmo = 1'b1;
            m_ok  = 1'b0;
            armed = 1'b0;
        end else if (rise) begin
            if (armed && in_low) publish(t_now - t_rise, t_fall - t_rise);
            armed  = 1'b1;
            in_low = 1'b0;
            t_rise = t_now;
        end else if (fall && armed && !in_low) begin
            in_low = 1'b1;
            t_fall = t_now;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step(PulseIn);
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("high_cnt",   high_cnt,   m_high);
            check("period_cnt", period_cnt, m_period);
            check("meas_valid", meas_valid, m_valid);
            check("mode_ok",    mode_ok,    m_ok);
            check("mode",       mode,       m_mode);
            check("timeout",    timeout,    m_tmo);
        end
        if (meas_valid) n_valid++;
    end

    task automatic drive(input bit lvl, input int n);
        PulseIn = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_periods(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic close_period();
        drive(1'b1, 10);
    endtask

    task automatic expect_last(input string tag, input int unsigned v0, input int d,
                               input longint hi, input longint per, input bit ok, input int md);
        check({tag, " valid count"}, longint'(n_valid - v0), d);
        check({tag, " high_cnt"}, high_cnt, hi);
        check({tag, " period_cnt"}, period_cnt, per);
        check({tag, " mode_ok"}, mode_ok, ok);
        check({tag, " mode"}, mode, md);
    endtask

    typedef struct { int hi; int lo; bit ok; int md; } bnd_t;
    bnd_t bnd [10] = '{
        '{75, 75, 1'b0, 0},   // 150: no mode window
        '{25, 75, 1'b0, 0},   // 100 at 25% duty
        '{48, 48, 1'b0, 0},   // 96: just below mode 0
        '{52, 52, 1'b0, 0},   // 104: just above mode 0
        '{53, 48, 1'b0, 0},   // 101, duty off by 5
        '{48, 49, 1'b1, 0},   // 97: lower edge of mode 0
        '{49, 52, 1'b1, 0},   // 101, duty off by exactly 3
        '{104, 103, 1'b0, 0}, // 207: just above mode 2
        '{243, 242, 1'b1, 1}, // 485: lower edge of mode 1
        '{103, 103, 1'b1, 2}  // 206: upper edge of mode 2
    };

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned v0;
        int          first_k;
        model_reset();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;

        // Mode 0 baseline: first publish after the second rise
        v0 = n_valid;
        drive(1'b0, 5);
        run_periods(50, 51, 1);
        check("t1 no publish on first rise", longint'(n_valid - v0), 0);
        close_period();
        expect_last("t1", v0, 1, 50, 101, 1'b1, 0);
        check("t1 timeout", timeout, 0);

        // Sweep modes 1..3
        for (int m = 1; m < 4; m++) begin
            drive(1'b0, 20);
            v0 = n_valid;
            run_periods(int'(noms[m] / 2), int'(noms[m] / 2), 3);
            close_period();
            expect_last($sformatf("t2 mode%0d", m), v0, 4, noms[m] / 2, noms[m], 1'b1, m);
        end
        cur_mode = 3;

        // Window boundaries and rejected periods; mode must hold while mode_ok=0
        foreach (bnd[i]) begin
            drive(1'b0, 20);
            v0 = n_valid;
            run_periods(bnd[i].hi, bnd[i].lo, 2);
            close_period();
            if (bnd[i].ok) cur_mode = bnd[i].md;
            expect_last($sformatf("t3 case%0d", i), v0, 3, bnd[i].hi,
                        bnd[i].hi + bnd[i].lo, bnd[i].ok, cur_mode);
        end

        // Constant high after one rise times out exactly TIMEOUT cycles after the rise
        drive(1'b0, 20);
        PulseIn = 1'b1;
        first_k = 0;
        for (int k = 1; k <= int'(TIMEOUT) + LAT + 20; k++) begin
            @(posedge clk);
            #1;
            if (timeout && first_k == 0) first_k = k;
        end
        check("t4 timeout cycle", first_k, TIMEOUT + LAT + 1);
        check("t4 timeout level", timeout, 1);
        check("t4 mode_ok", mode_ok, 0);
        check("t4 high_cnt held", high_cnt, 10);
        check("t4 period_cnt held", period_cnt, 30);
        check("t4 mode held", mode, cur_mode);
        drive(1'b0, 20);
        v0 = n_valid;
        drive(1'b1, 50);
        check("t4 timeout after restart rise", timeout, 1);
        check("t4 no publish on restart", longint'(n_valid - v0), 0);
        drive(1'b0, 51);
        close_period();
        expect_last("t4 recover", v0, 1, 50, 101, 1'b1, 0);
        check("t4 timeout cleared", timeout, 0);
        cur_mode = 0;

        // Reset in the middle of a high phase
        drive(1'b0, 20);
        run_periods(50, 51, 1);
        drive(1'b1, 20);
        rst_n = 1'b0;
        PulseIn = 1'b0;
        #1;
        check("t5 rst high_cnt", high_cnt, 0);
        check("t5 rst period_cnt", period_cnt, 0);
        check("t5 rst meas_valid", meas_valid, 0);
        check("t5 rst mode", mode, 0);
        check("t5 rst mode_ok", mode_ok, 0);
        check("t5 rst timeout", timeout, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0 = n_valid;
        drive(1'b0, 10);
        run_periods(50, 51, 1);
        check("t5 no publish after one rise", longint'(n_valid - v0), 0);
        close_period();
        expect_last("t5", v0, 1, 50, 101, 1'b1, 0);

        // Two-cycle low glitch inside the high phase of mode 0
        drive(1'b0, 20);
        v0 = n_valid;
        repeat (2) begin
            drive(1'b1, 20);
            drive(1'b0, 2);
            drive(1'b1, 28);
            drive(1'b0, 51);
        end
        close_period();
`ifdef GLITCH_FILTER_EN
        expect_last("t6 filtered", v0, 3, 50, 101, 1'b1, 0);
`else
        expect_last("t6 unfiltered", v0, 5, 28, 79, 1'b0, 0);
`endif

        // Randomized periods, a long low gap that times out, then more random periods
        for (int r = 0; r < 90; r++) begin
            int kind, x, tol, p, h;
            if (r == 60) drive(1'b0, TIMEOUT + 20);
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                x = (kind == 5) ? 3 : $urandom_range(0, 2);
                tol = int'(noms[x] >> TOL_SHIFT);
                p = int'(noms[x]) - tol - 2 + $urandom_range(0, 2 * tol + 4);
                h = p / 2 + $urandom_range(0, 6) - 3;
            end else if (kind <= 7) begin
                h = $urandom_range(1, 150);
                p = h + $urandom_range(1, 150);
            end else begin
                h = $urandom_range(1, 5);
                p = h + $urandom_range(1, 5);
            end
            if (h < 1) h = 1;
            if (p - h < 1) p = h + 1;
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
        close_period();
        drive(1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
